// File: rtl/bolme_param.sv
// Multi-cycle restoring divider, signed/unsigned per operation; done WIDTH+2 clocks after start (2 on divide-by-zero).
// Backpressure: start is only sampled while busy=0; starts during an operation are dropped, not queued.
module bolme_param #(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             isaretli,
   input  logic [WIDTH-1:0] bolunen,
   input  logic [WIDTH-1:0] bolen,
   output logic [WIDTH-1:0] bolum,
   output logic [WIDTH-1:0] kalan,
   output logic             busy,
   output logic             done,
   output logic             divisor_zero,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state;
   state_t           state_nxt;

   logic             accept;
   logic             calc_en;
   logic             fix_en;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dmag;
   logic [WIDTH-1:0] dividend_raw;
   logic             neg_q;
   logic             neg_r;
   logic             zero_op;
   logic             ovf_op;

   logic             signed_op;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             is_ovf;
   logic [WIDTH:0]   part;
   logic             ge;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;

   // Operand preparation on the raw inputs; only used in the accept cycle.
   assign signed_op = SIGNED_EN && isaretli;
   assign a_neg     = signed_op && bolunen[WIDTH-1];
   assign b_neg     = signed_op && bolen[WIDTH-1];
   assign a_mag     = a_neg ? (-bolunen) : bolunen;
   assign b_mag     = b_neg ? (-bolen) : bolen;
   assign is_ovf    = signed_op && (bolunen == MIN_VAL) && (bolen == {WIDTH{1'b1}});

   // Trial remainder: previous remainder shifted left with the next dividend bit.
   assign part = {rem, quo[WIDTH-1]};
   assign ge   = part >= {1'b0, dmag};
   // When ge holds the true difference is below dmag, so the low WIDTH bits are exact.
   assign diff = part[WIDTH-1:0] - dmag;

   assign q_fin = neg_q ? (-quo) : quo;
   assign r_fin = neg_r ? (-rem) : rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (bolen == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            if (cnt == CW'(1)) begin
               state_nxt = FIX;
            end
         end
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      accept  = (state == IDLE) && start;
      calc_en = (state == CALC);
      fix_en  = (state == FIX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bolum        <= '0;
         kalan        <= '0;
         done         <= 1'b0;
         divisor_zero <= 1'b0;
         overflow     <= 1'b0;
         cnt          <= '0;
         rem          <= '0;
         quo          <= '0;
         dmag         <= '0;
         dividend_raw <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         zero_op      <= 1'b0;
         ovf_op       <= 1'b0;
      end else begin
         done <= fix_en;

         if (accept) begin
            divisor_zero <= 1'b0;
            overflow     <= 1'b0;
            cnt          <= CW'(WIDTH);
            rem          <= '0;
            quo          <= a_mag;
            dmag         <= b_mag;
            dividend_raw <= bolunen;
            neg_q        <= a_neg ^ b_neg;
            neg_r        <= a_neg;
            zero_op      <= (bolen == '0);
            ovf_op       <= is_ovf;
         end

         // quo doubles as the dividend shift register and the quotient collector.
         if (calc_en) begin
            cnt <= cnt - CW'(1);
            if (ge) begin
               rem <= diff;
               quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
               rem <= part[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b0};
            end
         end

         if (fix_en) begin
            if (zero_op) begin
               bolum        <= '1;
               kalan        <= dividend_raw;
               divisor_zero <= 1'b1;
            end else if (ovf_op) begin
               bolum    <= MIN_VAL;
               kalan    <= '0;
               overflow <= 1'b1;
            end else begin
               bolum <= q_fin;
               kalan <= r_fin;
            end
         end
      end
   end

endmodule

// File: tb/tb_bolme_param.sv
// Directed bench for bolme_param: 4-bit and 8-bit instances plus an 8-bit unsigned-only instance.
module tb_bolme_param;

   logic       clk = 1'b0;
   logic       rst;

   logic       start8, isaretli8;
   logic [7:0] a8, b8;
   logic [7:0] q8, r8, q8u, r8u;
   logic       busy8, done8, dz8, ov8;
   logic       busy8u, done8u, dz8u, ov8u;

   logic       start4, isaretli4;
   logic [3:0] a4, b4, q4, r4;
   logic       busy4, done4, dz4, ov4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bolme_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
      .clk(clk), .rst(rst), .start(start8), .isaretli(isaretli8),
      .bolunen(a8), .bolen(b8), .bolum(q8), .kalan(r8),
      .busy(busy8), .done(done8), .divisor_zero(dz8), .overflow(ov8)
   );

   bolme_param #(.WIDTH(8), .SIGNED_EN(1'b0)) u8u (
      .clk(clk), .rst(rst), .start(start8), .isaretli(isaretli8),
      .bolunen(a8), .bolen(b8), .bolum(q8u), .kalan(r8u),
      .busy(busy8u), .done(done8u), .divisor_zero(dz8u), .overflow(ov8u)
   );

   bolme_param #(.WIDTH(4), .SIGNED_EN(1'b1)) u4 (
      .clk(clk), .rst(rst), .start(start4), .isaretli(isaretli4),
      .bolunen(a4), .bolen(b4), .bolum(q4), .kalan(r4),
      .busy(busy4), .done(done4), .divisor_zero(dz4), .overflow(ov4)
   );

   // Present one start to the 8-bit instances; returns #1 after the sampling edge.
   task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b);
      isaretli8 = s;
      a8        = a;
      b8        = b;
      start8    = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
   endtask

   // lat = clock edges from start sampling to the edge that samples done high; -1 on timeout.
   task automatic wait8(output int lat, output int bc);
      lat = -1;
      bc  = 0;
      for (int k = 0; k < 60; k++) begin
         if (busy8) bc++;
         if (done8) begin
            lat = k + 1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
      int bc;
      issue8(s, a, b);
      wait8(lat, bc);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start8 = 1'b0; isaretli8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; isaretli4 = 1'b0; a4 = '0; b4 = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (q8 !== 8'h00)   begin n_err++; $display("FAIL reset_bolum: got %h want 00", q8); end
      n_cmp++; if (r8 !== 8'h00)   begin n_err++; $display("FAIL reset_kalan: got %h want 00", r8); end
      n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy8); end
      n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done8); end
      n_cmp++; if (dz8 !== 1'b0)   begin n_err++; $display("FAIL reset_dz: got %b want 0", dz8); end
      n_cmp++; if (ov8 !== 1'b0)   begin n_err++; $display("FAIL reset_ov: got %b want 0", ov8); end
      n_cmp++; if ({q4, r4, busy4, done4, dz4, ov4} !== 12'h000)
         begin n_err++; $display("FAIL reset_w4: got %h want 000", {q4, r4, busy4, done4, dz4, ov4}); end
      rst = 1'b0;
   endtask

   task automatic test_unsigned_w4;
      int lat, bc;
      a4 = 4'd15; b4 = 4'd2; isaretli4 = 1'b0; start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      lat = -1; bc = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy4) bc++;
         if (done4) begin
            lat = k + 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      n_cmp++; if (lat !== 6)    begin n_err++; $display("FAIL w4_latency: got %0d want 6", lat); end
      n_cmp++; if (bc !== 5)     begin n_err++; $display("FAIL w4_busy_cycles: got %0d want 5", bc); end
      n_cmp++; if (q4 !== 4'd7)  begin n_err++; $display("FAIL w4_bolum: got %0d want 7", q4); end
      n_cmp++; if (r4 !== 4'd1)  begin n_err++; $display("FAIL w4_kalan: got %0d want 1", r4); end
      n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL w4_busy_in_done: got %b want 0", busy4); end
      @(posedge clk);
      #1;
      n_cmp++; if (done4 !== 1'b0) begin n_err++; $display("FAIL w4_done_single: got %b want 0", done4); end
   endtask

   task automatic test_signed;
      int lat;
      op8(1'b1, 8'hF9, 8'h02, lat);
      n_cmp++; if (lat !== 10)    begin n_err++; $display("FAIL s_latency: got %0d want 10", lat); end
      n_cmp++; if (q8 !== 8'hFD)  begin n_err++; $display("FAIL s_m7_2_bolum: got %h want fd", q8); end
      n_cmp++; if (r8 !== 8'hFF)  begin n_err++; $display("FAIL s_m7_2_kalan: got %h want ff", r8); end
      n_cmp++; if ({dz8, ov8} !== 2'b00) begin n_err++; $display("FAIL s_m7_2_flags: got %b want 00", {dz8, ov8}); end
      op8(1'b1, 8'hF9, 8'hFE, lat);
      n_cmp++; if (q8 !== 8'h03)  begin n_err++; $display("FAIL s_m7_m2_bolum: got %h want 03", q8); end
      n_cmp++; if (r8 !== 8'hFF)  begin n_err++; $display("FAIL s_m7_m2_kalan: got %h want ff", r8); end
      op8(1'b1, 8'h07, 8'hFE, lat);
      n_cmp++; if (q8 !== 8'hFD)  begin n_err++; $display("FAIL s_7_m2_bolum: got %h want fd", q8); end
      n_cmp++; if (r8 !== 8'h01)  begin n_err++; $display("FAIL s_7_m2_kalan: got %h want 01", r8); end
      op8(1'b0, 8'hF9, 8'h02, lat);
      n_cmp++; if (q8 !== 8'h7C)  begin n_err++; $display("FAIL u_249_2_bolum: got %h want 7c", q8); end
      n_cmp++; if (r8 !== 8'h01)  begin n_err++; $display("FAIL u_249_2_kalan: got %h want 01", r8); end
   endtask

   task automatic test_div_zero;
      int lat, bc;
      op8(1'b1, 8'h5A, 8'h00, lat);
      n_cmp++; if (lat !== 2)     begin n_err++; $display("FAIL dz_s_latency: got %0d want 2", lat); end
      n_cmp++; if (dz8 !== 1'b1)  begin n_err++; $display("FAIL dz_s_flag: got %b want 1", dz8); end
      n_cmp++; if (q8 !== 8'hFF)  begin n_err++; $display("FAIL dz_s_bolum: got %h want ff", q8); end
      n_cmp++; if (r8 !== 8'h5A)  begin n_err++; $display("FAIL dz_s_kalan: got %h want 5a", r8); end
      n_cmp++; if (ov8 !== 1'b0)  begin n_err++; $display("FAIL dz_s_ov: got %b want 0", ov8); end
      op8(1'b0, 8'h5A, 8'h00, lat);
      n_cmp++; if (lat !== 2)     begin n_err++; $display("FAIL dz_u_latency: got %0d want 2", lat); end
      n_cmp++; if ({dz8, q8, r8} !== {1'b1, 8'hFF, 8'h5A})
         begin n_err++; $display("FAIL dz_u_result: got %b/%h/%h want 1/ff/5a", dz8, q8, r8); end
      issue8(1'b0, 8'd20, 8'd6);
      n_cmp++; if (dz8 !== 1'b0)  begin n_err++; $display("FAIL dz_clear_at_start: got %b want 0", dz8); end
      n_cmp++; if (q8 !== 8'hFF)  begin n_err++; $display("FAIL dz_bolum_hold: got %h want ff", q8); end
      wait8(lat, bc);
      n_cmp++; if ({q8, r8} !== {8'd3, 8'd2})
         begin n_err++; $display("FAIL dz_next_result: got %0d r %0d want 3 r 2", q8, r8); end
   endtask

   task automatic test_overflow;
      int lat, bc;
      op8(1'b1, 8'h80, 8'hFF, lat);
      n_cmp++; if (q8 !== 8'h80)  begin n_err++; $display("FAIL ovf_bolum: got %h want 80", q8); end
      n_cmp++; if (r8 !== 8'h00)  begin n_err++; $display("FAIL ovf_kalan: got %h want 00", r8); end
      n_cmp++; if (ov8 !== 1'b1)  begin n_err++; $display("FAIL ovf_flag: got %b want 1", ov8); end
      n_cmp++; if (dz8 !== 1'b0)  begin n_err++; $display("FAIL ovf_dz: got %b want 0", dz8); end
      n_cmp++; if ({q8u, r8u, ov8u} !== {8'h00, 8'h80, 1'b0})
         begin n_err++; $display("FAIL ovf_signed_disabled: got %h/%h/%b want 00/80/0", q8u, r8u, ov8u); end
      issue8(1'b0, 8'h80, 8'hFF);
      n_cmp++; if (ov8 !== 1'b0)  begin n_err++; $display("FAIL ovf_clear_at_start: got %b want 0", ov8); end
      wait8(lat, bc);
      n_cmp++; if ({q8, r8, ov8} !== {8'h00, 8'h80, 1'b0})
         begin n_err++; $display("FAIL ovf_unsigned: got %h/%h/%b want 00/80/0", q8, r8, ov8); end
   endtask

   task automatic test_back_to_back;
      int k1, k2, dcnt;
      k1 = -1; k2 = -1; dcnt = 0;
      issue8(1'b0, 8'd100, 8'd7);
      for (int k = 0; k < 40; k++) begin
         if (k == 3) begin
            start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
         end else if (k == 4) begin
            start8 = 1'b0;
         end
         if (k1 >= 0 && k == k1 + 1) start8 = 1'b0;
         if (done8) begin
            dcnt++;
            if (k1 < 0) begin
               k1 = k;
               n_cmp++; if ({q8, r8} !== {8'd14, 8'd2})
                  begin n_err++; $display("FAIL b2b_first: got %0d r %0d want 14 r 2", q8, r8); end
               start8 = 1'b1; isaretli8 = 1'b0; a8 = 8'd9; b8 = 8'd3;
            end else begin
               k2 = k;
               n_cmp++; if ({q8, r8} !== {8'd3, 8'd0})
                  begin n_err++; $display("FAIL b2b_second: got %0d r %0d want 3 r 0", q8, r8); end
            end
         end
         @(posedge clk);
         #1;
      end
      n_cmp++; if (k1 !== 9)       begin n_err++; $display("FAIL b2b_first_latency: got %0d want 9", k1); end
      n_cmp++; if (k2 - k1 !== 10) begin n_err++; $display("FAIL b2b_gap: got %0d want 10", k2 - k1); end
      n_cmp++; if (dcnt !== 2)     begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", dcnt); end
   endtask

   task automatic test_reset_mid;
      int lat, dcnt;
      issue8(1'b0, 8'd100, 8'd7);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy8); end
      n_cmp++; if ({q8, r8, done8, dz8, ov8} !== 19'h0)
         begin n_err++; $display("FAIL rmid_outputs: got %h/%h/%b/%b/%b want zeros", q8, r8, done8, dz8, ov8); end
      dcnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done8) dcnt++;
      end
      n_cmp++; if (dcnt !== 0)     begin n_err++; $display("FAIL rmid_no_done: got %0d want 0", dcnt); end
      op8(1'b0, 8'd200, 8'd9, lat);
      n_cmp++; if (lat !== 10)     begin n_err++; $display("FAIL rmid_new_latency: got %0d want 10", lat); end
      n_cmp++; if ({q8, r8} !== {8'd22, 8'd2})
         begin n_err++; $display("FAIL rmid_new_result: got %0d r %0d want 22 r 2", q8, r8); end
   endtask

   initial begin
      test_reset;
      test_unsigned_w4;
      test_signed;
      test_div_zero;
      test_overflow;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bolme_param.md
Name: bolme_param

Overview:
- Parametrised, multi-cycle shift-subtract (restoring) integer divider; successor to the fixed 4-bit unsigned divider.
- Adds WIDTH generalisation, a per-operation signed/unsigned mode, a busy flag, signed-overflow detection, and back-to-back operation.
- Sits as a datapath helper beside control FSMs and is driven by a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- SIGNED_EN, 1, 1 = the isaretli input is honoured; 0 = isaretli is ignored and all operations are unsigned.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- isaretli  in  1  1 = two's-complement signed operation; latched with start.
- bolunen  in  WIDTH  dividend; latched with start.
- bolen  in  WIDTH  divisor; latched with start.
- bolum  out  WIDTH  quotient; registered.
- kalan  out  WIDTH  remainder; registered.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when results are valid.
- divisor_zero  out  1  the last operation had bolen=0.
- overflow  out  1  the last operation was signed MIN/-1.

Behaviour:
- Reset: synchronous, active-high. On rst=1 at an edge: state=IDLE; bolum, kalan, busy, done, divisor_zero and overflow all 0. Reset has priority over start and aborts any in-flight operation; no done is produced for the aborted operation.
- States: IDLE, CALC, FIX.
- IDLE: busy=0. On start=1 at edge E0:
  - latch the operands and the effective mode (isaretli & SIGNED_EN);
  - clear divisor_zero and overflow.
- IDLE, divisor zero: if the latched bolen=0, go directly to FIX marked divisor-zero; do not enter CALC.
- IDLE, otherwise: take absolute values if signed, load the counter with WIDTH, and enter CALC.
- CALC: one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits; subtract when the remainder ≥ the divisor magnitude. After WIDTH cycles, go to FIX.
- FIX (one cycle): write the outputs, pulse done=1 on the following cycle, and return to IDLE.
- Output rules at FIX, normal case:
  - quotient negated if the signs differ (truncation toward zero);
  - remainder takes the sign of the dividend;
  - always bolunen = bolum*bolen + kalan, with |kalan| < |bolen|.
- Output rules at FIX, divisor zero: bolum = all ones; kalan = bolunen (raw); divisor_zero=1.
- Output rules at FIX, signed overflow (bolunen = -2^(WIDTH-1), bolen = -1): bolum = -2^(WIDTH-1) (wrapped); kalan=0; overflow=1. The CALC path may run; only the flag and the forced values are required.
- Latency:
  - normal operation: done high in the cycle after edge E0+WIDTH+1, i.e. WIDTH+2 clocks after start is sampled;
  - divisor zero: done high 2 clocks after start is sampled.
- busy: rises the cycle after E0 and falls in the same cycle that done is high.
- done: exactly one cycle per accepted start. A start in the done cycle is accepted, giving back-to-back operation with no idle gap.
- Holding: bolum, kalan, divisor_zero and overflow hold until the next accepted start. The flags clear at acceptance; bolum and kalan keep their old values until the next FIX.
- start while busy=1 is ignored, not queued. Operand changes while busy have no effect.
- isaretli=0 or SIGNED_EN=0: pure unsigned; overflow is never set.

Test Plan:
- WIDTH=4, unsigned, bolunen=15, bolen=2, one-cycle start → bolum=7, kalan=1, done pulses exactly once, 6 clocks after start is sampled; busy high for 5 cycles.
- WIDTH=8, signed, bolunen=-7 (0xF9), bolen=2 → bolum=-3 (0xFD), kalan=-1 (0xFF); flags 0. Repeat with bolen=-2 → bolum=3, kalan=-1.
- WIDTH=8, bolen=0, bolunen=0x5A, either mode → done 2 clocks after start; divisor_zero=1, bolum=0xFF, kalan=0x5A. The next valid start clears divisor_zero.
- WIDTH=8, signed, bolunen=0x80, bolen=0xFF → bolum=0x80, kalan=0, overflow=1. The same operands unsigned → bolum=0, kalan=0x80, overflow=0.
- Start 100/7 unsigned, pulse start with 9/3 mid-CALC, then assert start again in the done cycle with 9/3 → first result 14 r 2; second result 3 r 0; exactly two done pulses, with the second WIDTH+2 clocks after the first.
- Assert rst=1 for one cycle mid-CALC → next cycle: busy=0, all outputs 0, no done pulse. A new start afterwards completes correctly.
